// File: rtl/pipe_register_chain.sv
// pipe_register_chain: elastic valid/ready register chain with bubble collapse and synchronous flush
module pipe_register_chain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  assign ready[DEPTH] = out_ready;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    // flattened form of !valid[g] | ready[g+1]: some stage at or past g is empty, or the output pops
    assign ready[g] = out_ready | ~&valid[DEPTH-1:g];
    if (g == 0) begin : g_head
      assign up_valid[g] = in_valid;
      assign up_data[g]  = in_data;
    end else begin : g_body
      assign up_valid[g] = valid[g-1];
      assign up_data[g]  = data[g-1];
    end
  end
  assign in_ready  = ready[0] & !flush;
  assign out_valid = valid[DEPTH-1] & !flush;
  assign out_data  = data[DEPTH-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VALUE;
    end else if (flush) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ready[i]) begin
          valid[i] <= up_valid[i];
          if (up_valid[i]) data[i] <= up_data[i];
        end
      occupancy <= occupancy + OW'(in_valid & in_ready) - OW'(out_valid & out_ready);
    end
endmodule

// File: tb/tb_pipe_register_chain.sv
// tb_pipe_register_chain: model-checked bench for a 3x4 and a 1x8 chain driven by directed vectors
module tb_pipe_register_chain;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic       fl3 = 0, iv3 = 0, or3 = 0;
  logic [3:0] id3 = 0;
  logic       ir3, ov3;
  logic [3:0] od3;
  logic [1:0] oc3;
  logic       fl1 = 0, iv1 = 0, or1 = 0;
  logic [7:0] id1 = 0;
  logic       ir1, ov1;
  logic [7:0] od1;
  logic [0:0] oc1;

  pipe_register_chain u3 (.clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(oc3));
  pipe_register_chain #(.WIDTH(8), .DEPTH(1)) u1 (.clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1),
    .in_ready(ir1), .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));

  int total = 0, bad = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  // model: slot 0 is the input end; words slide toward the output into any free slot ahead
  typedef struct packed {
    logic [15:0][7:0] d;
    logic [15:0]      v;
  } mdl_t;
  mdl_t m3 = '0, m1 = '0;

  function automatic bit m_ir(mdl_t m, int dep, bit fl, bit ordy);
    return !fl && (ordy || $countones(m.v) < dep);
  endfunction

  function automatic bit m_ov(mdl_t m, int dep, bit fl);
    return m.v[dep-1] && !fl;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int dep, bit fl, bit iv, logic [7:0] id, bit ordy);
    mdl_t n = m;
    bit acc = iv && m_ir(m, dep, fl, ordy);
    if (fl) begin
      n.v = '0;
      return n;
    end
    if (m_ov(m, dep, fl) && ordy) n.v[dep-1] = 0;
    for (int i = dep - 1; i >= 1; i--)
      if (!n.v[i] && n.v[i-1]) begin
        n.d[i] = n.d[i-1];
        n.v[i] = 1;
        n.v[i-1] = 0;
      end
    if (acc) begin
      n.d[0] = id;
      n.v[0] = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m3 <= '0;
      m1 <= '0;
    end else begin
      m3 <= mstep(m3, 3, fl3, iv3, {4'b0, id3}, or3);
      m1 <= mstep(m1, 1, fl1, iv1, id1, or1);
    end

  always @(negedge clk)
    if (!rst) begin
      chk("ready3", ir3, m_ir(m3, 3, fl3, or3));
      chk("valid3", ov3, m_ov(m3, 3, fl3));
      chk("occ3", oc3, $countones(m3.v));
      if (m3.v[2]) chk("data3", od3, m3.d[2][3:0]);
      chk("ready1", ir1, m_ir(m1, 1, fl1, or1));
      chk("valid1", ov1, m_ov(m1, 1, fl1));
      chk("occ1", oc1, $countones(m1.v));
      if (m1.v[0]) chk("data1", od1, m1.d[0]);
    end

  task automatic s3(bit v, logic [3:0] d, bit r, bit f);
    @(posedge clk);
    #1;
    iv3 = v; id3 = d; or3 = r; fl3 = f;
    @(negedge clk);
  endtask

  task automatic s1(bit v, logic [7:0] d, bit r, bit f);
    @(posedge clk);
    #1;
    iv1 = v; id1 = d; or1 = r; fl1 = f;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov3", ov3, 0); chk("rst_oc3", oc3, 0); chk("rst_od3", od3, 0);
    chk("rst_ov1", ov1, 0); chk("rst_od1", od1, 0);
    rst = 0;
    s3(0, 0, 1, 0);
    chk("rst_ir3", ir3, 1);
    // latency
    s3(1, 4'hA, 1, 0);
    s3(0, 0, 1, 0); chk("lat_occ", oc3, 1);
    s3(0, 0, 1, 0); chk("lat_ov_early", ov3, 0);
    s3(0, 0, 1, 0); chk("lat_ov", ov3, 1); chk("lat_od", od3, 4'hA); chk("lat_occ3", oc3, 1);
    s3(0, 0, 1, 0); chk("lat_ov_gone", ov3, 0); chk("lat_occ0", oc3, 0);
    // streaming
    for (int k = 1; k <= 8; k++) begin
      s3(1, 4'(k), 1, 0);
      if (k == 8) begin chk("str_od", od3, 5); chk("str_occ", oc3, 3); end
    end
    repeat (4) s3(0, 0, 1, 0);
    // backpressure and fill
    s3(1, 4'h3, 0, 0); s3(1, 4'h5, 0, 0); s3(1, 4'h7, 0, 0); s3(1, 4'h9, 0, 0);
    chk("fill_ir", ir3, 0); chk("fill_occ", oc3, 3); chk("fill_od", od3, 4'h3);
    s3(1, 4'h9, 0, 0); chk("fill_hold", od3, 4'h3);
    s3(1, 4'h9, 1, 0); chk("fill_pop_ir", ir3, 1);
    s3(0, 0, 0, 0); chk("fill_occ2", oc3, 3); chk("fill_od2", od3, 4'h5);
    repeat (4) s3(0, 0, 1, 0);
    // bubble collapse
    s3(1, 4'h1, 0, 0); s3(0, 0, 0, 0); s3(0, 0, 0, 0);
    s3(1, 4'h2, 0, 0); s3(0, 0, 0, 0); s3(0, 0, 0, 0);
    chk("bub_occ", oc3, 2); chk("bub_ir", ir3, 1); chk("bub_od", od3, 4'h1); chk("bub_ov", ov3, 1);
    repeat (3) s3(0, 0, 1, 0);
    // flush
    s3(1, 4'hC, 0, 0); s3(1, 4'hD, 0, 0); s3(1, 4'hE, 0, 0);
    s3(1, 4'hF, 1, 1); chk("fl_ir", ir3, 0); chk("fl_ov", ov3, 0);
    s3(1, 4'hF, 1, 0); chk("fl_occ", oc3, 0); chk("fl_ov_next", ov3, 0); chk("fl_ir_next", ir3, 1);
    s3(0, 0, 1, 0); s3(0, 0, 1, 0); chk("fl_lat_early", ov3, 0);
    s3(0, 0, 1, 0); chk("fl_lat_ov", ov3, 1); chk("fl_lat_od", od3, 4'hF);
    s3(0, 0, 1, 0);
    // asynchronous reset while streaming
    for (int k = 2; k <= 6; k++) s3(1, 4'(k), 1, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ov", ov3, 0); chk("arst_occ", oc3, 0); chk("arst_od", od3, 0);
    iv3 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    s3(0, 0, 1, 0); chk("arst_ir", ir3, 1); chk("arst_occ2", oc3, 0);
    // depth 1, width 8: streaming
    for (int k = 0; k < 6; k++) begin
      s1(1, 8'(8'h11 * (k + 1)), 1, 0);
      if (k == 3) begin chk("d1_str_od", od1, 8'h33); chk("d1_str_ov", ov1, 1); end
    end
    s1(0, 0, 1, 0);
    // depth 1: fill at one word
    s1(1, 8'hA1, 0, 0); s1(1, 8'hB2, 0, 0);
    chk("d1_fill_ir", ir1, 0); chk("d1_fill_occ", oc1, 1); chk("d1_fill_od", od1, 8'hA1);
    s1(1, 8'hB2, 1, 0); chk("d1_pop_ir", ir1, 1);
    s1(0, 0, 0, 0); chk("d1_od2", od1, 8'hB2); chk("d1_occ2", oc1, 1);
    s1(0, 0, 1, 0); s1(0, 0, 1, 0); chk("d1_empty", oc1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_register_chain.md
Name: pipe_register_chain

Overview:
- Parametrised, elastic pipeline register: a chain of DEPTH load-enabled register stages, each WIDTH bits wide.
- Each stage carries a valid bit. Stages are linked by a valid/ready handshake with bubble collapsing and a synchronous flush.
- Replaces hand-chained single parallel registers wherever a datapath needs fixed latency plus backpressure, e.g. between the input capture logic and the processing/display stages.

Parameters:
- WIDTH, 4, data bits per stage.
- DEPTH, 3, number of register stages; legal range 1..16.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every data register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  last stage holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  last-stage data register.
- occupancy  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Behaviour:
- One clock; reset is asynchronous and active-high.
- **Reset (rst=1, any time, including mid-transfer):**
  - All stage valid bits are cleared immediately.
  - All data registers take RESET_VALUE.
  - out_valid=0, out_data=RESET_VALUE, occupancy=0.
  - in_ready=1 after rst deasserts, provided flush=0.
  - Words in flight are lost; there is no partial state.
- **Stage indexing and ready chain:**
  - Stage 0 takes input; stage DEPTH-1 drives out_data/out_valid.
  - ready[DEPTH] = out_ready.
  - ready[i] = !valid[i] | ready[i+1].
  - in_ready = ready[0] & !flush.
  - The ready path is combinational through the chain, with no registered ready.
- **Transfer into stage i on a rising edge** occurs when ready[i]=1, flush=0, and the upstream holds valid data:
  - For stage 0, the upstream condition is in_valid.
  - For stage i>0, it is valid[i-1].
  - On transfer: data[i] <= upstream data, valid[i] <= 1.
- **Vacating stage i:** if ready[i+1]=1 and nothing transfers in, valid[i] <= 0. data[i] keeps its old value and is don't-care.
- **Hold:** when ready[i]=0, data[i] and valid[i] are unchanged. While out_valid=1 and out_ready=0, out_data is stable.
- **Latency and throughput:**
  - A word accepted at edge N into an empty chain is on out_data with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles of register delay.
  - Sustained throughput is one word per cycle when out_ready=1.
- **Bubble collapse:** an empty stage always accepts, even if downstream is stalled. A chain with a stalled output therefore fills fully; in_ready drops only when all DEPTH stages are valid and out_ready=0.
- **Full with simultaneous pop:** all stages valid and out_ready=1 gives in_ready=1. The chain shifts, a new word enters, and occupancy is unchanged.
- **Flush:**
  - During the flush cycle, in_ready=0 and out_valid is masked to 0, so no handshake completes on either side.
  - At the next edge all valid bits clear; data registers hold their values.
  - occupancy=0 from the following cycle.
  - flush takes priority over every transfer; rst takes priority over flush.
- **occupancy:** registered count of set valid bits. It is updated every edge as +1 on accept only, −1 on output handshake only, and 0 on flush or reset.
- **Protocol rules:**
  - in_valid may be asserted regardless of in_ready; the word transfers only on in_valid & in_ready.
  - out_valid never deasserts without a handshake, except by flush or rst.

Test Plan:
- **Latency:** DEPTH=3, WIDTH=4, out_ready=1; push 4'hA for one cycle → out_valid=1 with out_data=4'hA exactly 3 edges later, for one cycle; occupancy 1,1,1 then 0.
- **Streaming:** out_ready=1; push 4'h1..4'h8 on consecutive cycles → identical sequence out, no gaps; in_ready constantly 1; occupancy settles at 3.
- **Backpressure/fill:** out_ready=0; push 4'h3,4'h5,4'h7,4'h9 back-to-back → in_ready=0 after the third accept; 4'h9 is held at the input; out_data=4'h3 stable; occupancy=3. Raise out_ready → 4'h3 leaves and 4'h9 enters in the same cycle; occupancy stays 3.
- **Bubble collapse:** push 4'h1, idle 2 cycles, push 4'h2, with out_ready=0 → both words end up in stages 2 and 1 with no gap; occupancy=2; in_ready=1.
- **Flush:** chain full of 4'hC,4'hD,4'hE; assert flush for one cycle with in_valid=1, out_ready=1 → no handshake that cycle; out_valid=0 and occupancy=0 next cycle; the next pushed word 4'hF emerges with full DEPTH latency.
- **Async reset mid-operation:** assert rst between clock edges while streaming → out_valid, occupancy and out_data go to 0 before the next edge. Also rerun the streaming and fill scenarios with DEPTH=1 and WIDTH=8 to confirm the parameter edge case: latency 1, full at 1 word.
